// File: rtl/smag_conv_arbiter.sv
// smag_conv_arbiter
// Two requesters share a single sign-magnitude to two's-complement converter.
// Arbitration is round-robin. The winner's operand is captured in IDLE, converted
// in CONV, and the result is held in HOLD until the consumer acknowledges it.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   req0/a0/s0        requester 0: request level, magnitude, sign (1 = negative)
//   req1/a1/s1        requester 1: request level, magnitude, sign
//   gnt0/gnt1         one-cycle pulse during CONV: that requester's operand was captured
//   out/out_id        registered result and the index of the requester that owns it
//   out_valid         result valid; held until out_ack is seen in HOLD
//   out_ack           consumer accepts out (ignored outside HOLD)
//   conv_count        acknowledged conversions, modulo 256
module smag_conv_arbiter #(
   parameter int unsigned N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [N-1:0] a0,
   input  logic         s0,
   input  logic         req1,
   input  logic [N-1:0] a1,
   input  logic         s1,
   output logic         gnt0,
   output logic         gnt1,
   output logic [N-1:0] out,
   output logic         out_valid,
   output logic         out_id,
   input  logic         out_ack,
   output logic [7:0]   conv_count
);

   typedef enum logic [1:0] {StIdle, StConv, StHold} state_e;

   state_e       state_q, state_d;
   logic         prio_q, prio_d;
   logic [N-1:0] op_a_q, op_a_d;
   logic         op_s_q, op_s_d;
   logic         op_id_q, op_id_d;
   logic         gnt0_q, gnt0_d;
   logic         gnt1_q, gnt1_d;
   logic [N-1:0] out_q, out_d;
   logic         out_valid_q, out_valid_d;
   logic         out_id_q, out_id_d;
   logic [7:0]   count_q, count_d;

   logic         win_id;
   logic [N-1:0] conv_res;

   // Winner selection: contention resolved by prio, otherwise the lone requester.
   always_comb begin
      win_id = 1'b0;
      if (req0 && req1) begin
         win_id = prio_q;
      end else begin
         win_id = req1;
      end
   end

   // The single shared conversion path; carry out of the increment is dropped.
   always_comb begin
      conv_res = op_a_q;
      if (op_s_q) begin
         conv_res = (~op_a_q) + N'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      op_a_d      = op_a_q;
      op_s_d      = op_s_q;
      op_id_d     = op_id_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      count_d     = count_q;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               op_a_d  = win_id ? a1 : a0;
               op_s_d  = win_id ? s1 : s0;
               op_id_d = win_id;
               gnt0_d  = ~win_id;
               gnt1_d  = win_id;
               state_d = StConv;
            end
         end
         StConv: begin
            out_d       = conv_res;
            out_id_d    = op_id_q;
            out_valid_d = 1'b1;
            state_d     = StHold;
         end
         StHold: begin
            if (out_ack) begin
               out_valid_d = 1'b0;
               count_d     = count_q + 8'd1;
               // Hand priority to the requester that was not just served.
               prio_d      = ~out_id_q;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         prio_q      <= 1'b0;
         op_a_q      <= '0;
         op_s_q      <= 1'b0;
         op_id_q     <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= 1'b0;
         count_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         op_a_q      <= op_a_d;
         op_s_q      <= op_s_d;
         op_id_q     <= op_id_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         count_q     <= count_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign out_id     = out_id_q;
   assign conv_count = count_q;

endmodule

// File: doc/smag_conv_arbiter.md
SMAG_CONV_ARBITER -- requirements
Module: smag_conv_arbiter

Interface
REQ-001 Parameter: N, default 5, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 wants a conversion.
REQ-005 a0  input  N  requester 0 magnitude.
REQ-006 s0  input  1  requester 0 sign (1 = negative).
REQ-007 req1  input  1  requester 1 wants a conversion.
REQ-008 a1  input  N  requester 1 magnitude.
REQ-009 s1  input  1  requester 1 sign.
REQ-010 gnt0  output  1  registered one-cycle pulse: requester 0 operand captured.
REQ-011 gnt1  output  1  registered one-cycle pulse: requester 1 operand captured.
REQ-012 out  output  N  registered two's-complement result.
REQ-013 out_valid  output  1  out and out_id are valid; held until acknowledged.
REQ-014 out_id  output  1  index of the requester that owns out.
REQ-015 out_ack  input  1  consumer accepts out.
REQ-016 conv_count  output  8  number of completed (acknowledged) conversions, wraps modulo 256.

Function
REQ-017 The block SHALL own exactly one sign-magnitude-to-two's-complement conversion path, shared by both requesters.
REQ-018 Conversion SHALL be: sign 0 -> out = a; sign 1 -> out = (~a + 1) mod 2^N; carry out discarded.
REQ-019 Arithmetic boundaries: a=0,sign=1 -> out=0; a=2^(N-1),sign=1 -> out=2^(N-1); a=2^N-1,sign=1 -> out=1.
REQ-020 FSM states SHALL be IDLE, CONV, HOLD; reset state IDLE.
REQ-021 IDLE: if req0 or req1 sampled high, capture winner's a/sign/index into operand registers, go to CONV; else stay.
REQ-022 Arbitration SHALL be round-robin: pointer prio (reset 0); both requesting -> winner = prio; one requesting -> that one wins.
REQ-023 gnt of the winner SHALL be high for exactly the CONV cycle; the other gnt low; both gnts low in IDLE and HOLD.
REQ-024 CONV: result of conversion on operand registers SHALL be registered into out, out_id set, out_valid set, go to HOLD (always one cycle).
REQ-025 HOLD: out, out_id, out_valid SHALL be stable; out_ack sampled high -> out_valid cleared, conv_count incremented, prio set to the other index of out_id, go to IDLE.
REQ-026 out_ack outside HOLD SHALL be ignored.
REQ-027 Requests arriving in CONV or HOLD SHALL not be captured; req is level-sensitive and re-evaluated in IDLE.
REQ-028 A requester holding req high after its gnt SHALL be served again only per round-robin order.
REQ-029 Operand inputs SHALL be sampled only at the IDLE capture edge; later changes do not affect out.
REQ-030 Minimum throughput: 3 cycles per conversion with out_ack high in the first HOLD cycle.
REQ-031 out SHALL retain its last value after acknowledge until the next CONV overwrites it.
REQ-032 conv_count SHALL wrap 255 -> 0 without side effects.

Reset
REQ-033 rst high at an edge SHALL force state IDLE, prio 0, gnt0=gnt1=0, out=0, out_id=0, out_valid=0, conv_count=0, operand registers 0.
REQ-034 rst SHALL dominate all other inputs, including mid-CONV or mid-HOLD; an in-flight conversion is discarded and not counted.
REQ-035 First IDLE cycle after rst deassertion SHALL accept requests.

Verification
REQ-036 N=5, req0 only, a0=3, s0=1, out_ack held high -> gnt0 pulse cycle 2, out=5'b11101, out_valid cycle 3, out_id=0, conv_count=1, back to IDLE.
REQ-037 Boundaries on requester 1: (a=0,s=1)->0; (a=16,s=1)->16; (a=31,s=1)->1; (a=9,s=0)->9; out_id=1 each.
REQ-038 req0 and req1 held high continuously, ack immediate -> grants alternate 0,1,0,1; out_id alternates; conv_count=4 after 12 cycles.
REQ-039 out_ack withheld 5 cycles in HOLD while a0 changes -> out and out_valid stable, no new gnt; ack -> out_valid low next cycle.
REQ-040 rst asserted during HOLD -> next cycle all outputs zero, conv_count unchanged from 0-reset value, pending result lost; 256 acked conversions -> conv_count wraps to 0.
